// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO draining into an 8N1 serial transmitter, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             clr_ovf,
    output logic             uart_rxd_out,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic [CNT_W-1:0] fifo_count,
    output logic             tx_busy,
    output logic             overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [BW-1:0] baud;
    logic          pop, push, bit_done;
`ifdef UART_TX_PARITY_EN
    logic          par;
`endif

    assign fifo_full  = fifo_count == CNT_W'(FIFO_DEPTH);
    assign fifo_empty = fifo_count == '0;
    assign pop        = state == IDLE && !fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the write
    assign push       = wr_en && (!fifo_full || pop);
    assign bit_done   = baud == BW'(CLKS_PER_BIT - 1);
    assign tx_busy    = state != IDLE || !fifo_empty;

    // Storage array, written only on accepted pushes
    always_ff @(posedge clk)
        if (push) mem[wptr] <= wr_data;

    // Pointers, occupancy and sticky overflow (a dropped write beats a clear)
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            wptr       <= wptr + AW'(push);
            rptr       <= rptr + AW'(pop);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            overflow   <= (wr_en && !push) || (overflow && !clr_ovf);
        end

    // Serial engine; the line is registered from the current state and trails it by one cycle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state        <= IDLE;
            shift        <= '0;
            bit_idx      <= '0;
            baud         <= '0;
            uart_rxd_out <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par          <= 1'b0;
`endif
        end else begin
            baud <= (state == IDLE || bit_done) ? '0 : baud + 1'b1;
            case (state)
                IDLE: if (pop) begin
                    shift <= mem[rptr];
`ifdef UART_TX_PARITY_EN
                    par   <= ^mem[rptr];
`endif
                    state <= START;
                end
                START: if (bit_done) begin
                    bit_idx <= '0;
                    state   <= DATA;
                end
                DATA: if (bit_done) begin
                    shift   <= shift >> 1;
                    bit_idx <= bit_idx + 1'b1;
`ifdef UART_TX_PARITY_EN
                    if (bit_idx == 3'd7) state <= PARITY;
`else
                    if (bit_idx == 3'd7) state <= STOP;
`endif
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (bit_done) state <= STOP;
`endif
                STOP: if (bit_done) state <= IDLE;
                default: state <= IDLE;
            endcase
`ifdef UART_TX_PARITY_EN
            uart_rxd_out <= state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par : 1'b1;
`else
            uart_rxd_out <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
`endif
        end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed + randomized bench for uart_tx_fifo with a frame decoder and byte-queue reference.
module tb_uart_tx_fifo;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * CPB;
`else
    localparam int FRAME = 10 * CPB;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic wr4 = 1'b0, wr16 = 1'b0, clr4 = 1'b0, clr16 = 1'b0;
    logic [7:0] d4 = '0, d16 = '0;
    logic line4, full4, empty4, busy4, ovf4;
    logic line16, full16, empty16, busy16, ovf16;
    logic [2:0] cnt4;
    logic [4:0] cnt16;
    int checks = 0, failures = 0, cyc = 0;
    logic [7:0] got4[$], got16[$], exp4[$], exp16[$];
    int start4[$];

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .CNT_W(3)) u4 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr4), .wr_data(d4), .clr_ovf(clr4),
        .uart_rxd_out(line4), .fifo_full(full4), .fifo_empty(empty4),
        .fifo_count(cnt4), .tx_busy(busy4), .overflow(ovf4));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .CNT_W(5)) u16 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr16), .wr_data(d16), .clr_ovf(clr16),
        .uart_rxd_out(line16), .fifo_full(full16), .fifo_empty(empty16),
        .fifo_count(cnt16), .tx_busy(busy16), .overflow(ovf16));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ln(input bit sel);
        return sel ? line16 : line4;
    endfunction

    // UART receiver: samples each bit mid-way, drops frames that overlap a reset
    task automatic mon(input bit sel);
        logic [7:0] b;
        logic p, s;
        bit ok;
        int t0;
        forever begin
            @(negedge clk);
            if (rst_n && ln(sel) === 1'b0) begin
                t0 = cyc;
                b = '0;
                p = 1'b0;
                repeat (CPB / 2) @(negedge clk);
                ok = rst_n && ln(sel) === 1'b0;
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    ok &= rst_n;
                    b[k] = ln(sel);
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                ok &= rst_n;
                p = ln(sel);
`endif
                repeat (CPB) @(negedge clk);
                ok &= rst_n;
                s = ln(sel);
                if (ok) begin
                    chk("stop_bit", s, 1'b1);
`ifdef UART_TX_PARITY_EN
                    chk("parity_bit", p, ^b);
`endif
                    if (sel) got16.push_back(b);
                    else begin
                        got4.push_back(b);
                        start4.push_back(t0);
                    end
                end
            end
        end
    endtask

    initial mon(1'b0);
    initial mon(1'b1);

    // Caller is at a negedge; returns at the next negedge, after the write edge
    task automatic wr(input bit sel, input logic [7:0] b);
        if (sel) begin wr16 = 1'b1; d16 = b; end
        else begin wr4 = 1'b1; d4 = b; end
        @(negedge clk);
        wr16 = 1'b0;
        wr4 = 1'b0;
    endtask

    task automatic wait_got(input bit sel, input int n, input int bound, input string tag);
        int i = 0;
        while ((sel ? got16.size() : got4.size()) < n && i < bound) begin
            @(negedge clk);
            i++;
        end
        chk(tag, sel ? got16.size() : got4.size(), n);
    endtask

    task automatic wait_idle4(input string tag);
        int i = 0;
        while (busy4 && i < 8 * FRAME) begin
            @(negedge clk);
            i++;
        end
        chk(tag, busy4, 1'b0);
    endtask

    task automatic cmpq(input bit sel, input string tag);
        int n = sel ? exp16.size() : exp4.size();
        chk({tag, "_len"}, sel ? got16.size() : got4.size(), n);
        for (int i = 0; i < n; i++) begin
            if (sel && i < got16.size()) chk($sformatf("%s[%0d]", tag, i), got16[i], exp16[i]);
            if (!sel && i < got4.size()) chk($sformatf("%s[%0d]", tag, i), got4[i], exp4[i]);
        end
    endtask

    initial begin
        logic [7:0] b [8];
        logic [7:0] rb [2];
        int roff [2];
        int c0, pe, w;

        repeat (3) @(negedge clk);
        chk("rst_line", line4, 1'b1);
        chk("rst_empty", empty4, 1'b1);
        chk("rst_full", full4, 1'b0);
        chk("rst_count", cnt4, 3'd0);
        chk("rst_busy", busy4, 1'b0);
        chk("rst_ovf", ovf4, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte: start bit two cycles after the write edge, busy across the frame
        wr(1'b0, 8'h55);
        exp4.push_back(8'h55);
        c0 = cyc;
        chk("t1_busy_after_wr", busy4, 1'b1);
        @(negedge clk);
        chk("t1_line_still_high", line4, 1'b1);
        while (cyc < c0 + FRAME - 2) @(negedge clk);
        chk("t1_busy_in_stop", busy4, 1'b1);
        wait_got(1'b0, 1, 4 * FRAME, "t1_frame_seen");
        chk("t1_start_latency", start4[0], c0 + 2);
        while (cyc < c0 + FRAME + 2) @(negedge clk);
        chk("t1_busy_done", busy4, 1'b0);
        chk("t1_line_idle", line4, 1'b1);

        // Back-to-back: exactly one idle cycle between frames
        wr(1'b0, 8'hA3);
        wr(1'b0, 8'h0F);
        exp4.push_back(8'hA3);
        exp4.push_back(8'h0F);
        wait_got(1'b0, 3, 6 * FRAME, "t2_frames_seen");
        if (start4.size() >= 3) chk("t2_frame_spacing", start4[2] - start4[1], FRAME + 1);
        wait_idle4("t2_idle");
        cmpq(1'b0, "t2_bytes");

        // Overflow with depth 4: six writes, one goes to the engine, one is dropped
        for (int k = 0; k < 8; k++) b[k] = 8'($urandom);
        wr(1'b0, b[0]);
        c0 = cyc;
        for (int k = 1; k < 6; k++) wr(1'b0, b[k]);
        for (int k = 0; k < 5; k++) exp4.push_back(b[k]);
        chk("t3_full", full4, 1'b1);
        chk("t3_count", cnt4, 3'd4);
        chk("t3_ovf", ovf4, 1'b1);
        clr4 = 1'b1;
        @(negedge clk);
        clr4 = 1'b0;
        chk("t3_ovf_cleared", ovf4, 1'b0);

        // Write into a full FIFO on the very edge the engine pops the next byte
        pe = c0 + 1 + FRAME + 1;
        while (cyc < pe - 1) @(negedge clk);
        chk("t4_count_pre", cnt4, 3'd4);
        wr(1'b0, b[6]);
        exp4.push_back(b[6]);
        chk("t4_count_same", cnt4, 3'd4);
        chk("t4_no_ovf", ovf4, 1'b0);
        chk("t4_full", full4, 1'b1);
        wr4 = 1'b1;
        d4 = b[7];
        clr4 = 1'b1;
        @(negedge clk);
        wr4 = 1'b0;
        clr4 = 1'b0;
        chk("t4_set_beats_clr", ovf4, 1'b1);
        chk("t4_count_after_drop", cnt4, 3'd4);
        wait_got(1'b0, exp4.size(), 10 * FRAME, "t4_frames_seen");
        wait_idle4("t4_idle");
        cmpq(1'b0, "t4_bytes");
        clr4 = 1'b1;
        @(negedge clk);
        clr4 = 1'b0;

        // Reset mid-frame: once in DATA of 0xFF, once in START of a random byte
        rb[0] = 8'hFF;
        rb[1] = 8'($urandom);
        roff[0] = 3 * CPB - 1;
        roff[1] = 1;
        for (int p = 0; p < 2; p++) begin
            wr(1'b0, rb[p]);
            c0 = cyc;
            wr(1'b0, 8'($urandom));
            while (cyc < c0 + 2 + roff[p]) @(negedge clk);
            chk($sformatf("t5_line_pre%0d", p), line4, p == 0 ? 1'b1 : 1'b0);
            chk($sformatf("t5_count_pre%0d", p), cnt4, 3'd1);
            #2 rst_n = 1'b0;
            #1;
            chk($sformatf("t5_line_rst%0d", p), line4, 1'b1);
            chk($sformatf("t5_count_rst%0d", p), cnt4, 3'd0);
            chk($sformatf("t5_busy_rst%0d", p), busy4, 1'b0);
            repeat (10) @(negedge clk);
            rst_n = 1'b1;
            repeat (FRAME + 10) @(negedge clk);
            chk($sformatf("t5_no_frame%0d", p), got4.size(), exp4.size());
        end
        wr(1'b0, 8'h01);
        exp4.push_back(8'h01);
        wait_got(1'b0, exp4.size(), 4 * FRAME, "t5_frame_seen");
        cmpq(1'b0, "t5_bytes");

        // Random stream through the depth-16 instance, polling full like firmware would
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 60)) @(negedge clk);
            w = 0;
            while (full16 && w < 4 * FRAME) begin
                @(negedge clk);
                w++;
            end
            b[0] = 8'($urandom);
            wr(1'b1, b[0]);
            exp16.push_back(b[0]);
        end
        wait_got(1'b1, 40, 20 * FRAME, "t6_frames_seen");
        cmpq(1'b1, "t6_bytes");
        chk("t6_ovf", ovf16, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Memory-mapped UART transmitter with byte FIFO, directly downstream of the mmio/gpio store path.
- CPU byte stores to the TX data register push into the FIFO. A bit-serial engine drains the FIFO onto the board TX pin (uart_rxd_out), 8N1, LSB first.
- Status outputs feed the gpio load mux so firmware can poll full/busy before storing.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 2
FIFO_DEPTH, 16, FIFO entries; power of two, >= 2
CNT_W, 5, width of fifo_count; must equal log2(FIFO_DEPTH)+1

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  one-cycle pulse: store to TX data register (gpio decode && store_enable && is_sb/is_sh/is_sw)
wr_data  input  8  byte to transmit (data_in[7:0])
clr_ovf  input  1  one-cycle pulse: clear sticky overflow flag
uart_rxd_out  output  1  serial TX line to host, idle high
fifo_full  output  1  FIFO holds FIFO_DEPTH entries
fifo_empty  output  1  FIFO holds 0 entries
fifo_count  output  CNT_W  current FIFO occupancy, 0..FIFO_DEPTH
tx_busy  output  1  serial engine not IDLE, or FIFO not empty
overflow  output  1  sticky: a write was dropped because FIFO was full

Behaviour:
- Reset (async assert, sync-safe deassert):
  - uart_rxd_out=1, FIFO pointers and count = 0, fifo_empty=1, fifo_full=0, tx_busy=0, overflow=0, state=IDLE, bit counter = 0, baud counter = 0.
  - Reset mid-frame aborts the frame immediately; the line returns high, no glitch low.
- FIFO:
  - Circular buffer; read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - Push on wr_en when not full. Occupancy and flags update on the next edge.
  - Push while full: byte dropped, overflow set to 1 next cycle, pointers unchanged.
  - Push and pop in the same cycle:
    - Count unchanged.
    - If the FIFO was full, the push is accepted (no overflow).
    - If the FIFO was empty, there is no pop: the push proceeds and the byte is popped on a later cycle.
  - clr_ovf clears overflow. If clr_ovf and an overflowing write occur in the same cycle, set wins.
- Serial FSM, states IDLE, START, DATA, STOP, baud counter 0..CLKS_PER_BIT-1:
  - IDLE: line=1. If FIFO not empty, pop the head into an 8-bit shift register, go to START, zero the baud counter. Line goes low on the cycle after the pop decision.
  - START: line=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: line=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit index 7 completes, go to STOP.
  - STOP: line=1 for CLKS_PER_BIT cycles, then IDLE.
  - Back-to-back bytes: IDLE lasts exactly 1 cycle between the stop bit and the next start bit.
- Latency: first push into an idle, empty block → line falls low 2 clk after the wr_en edge. A frame is 10*CLKS_PER_BIT cycles.
- uart_rxd_out is driven from a flop (no combinational path).
- tx_busy = (state != IDLE) | !fifo_empty, registered-consistent with state/count.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP. The line carries the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state, 8N1, 10-bit frames; no parity logic is synthesized.

Test Plan:
1. CLKS_PER_BIT=4, write 0x55 once → line low at cycle+2; bits 1,0,1,0,1,0,1,0 at 4-cycle spacing; stop high. tx_busy falls after 40 cycles. With UART_TX_PARITY_EN: parity bit 0, 44 cycles.
2. Write 0xA3, 0x0F back-to-back → two frames separated by exactly 1 idle-high cycle. Bench decodes 0xA3 then 0x0F.
3. FIFO_DEPTH=4, engine held busy: write 6 bytes → fifo_full=1 after 4 are held, overflow=1, fifo_count=4. Decoded output = the first 5 bytes (one was popped into the engine), the 6th is dropped.
4. Full FIFO with pop and wr_en in the same cycle → write accepted, overflow stays 0, count stays 4. clr_ovf together with an overflowing write → overflow=1.
5. Assert rst_n low mid-DATA of byte 0xFF → line=1 immediately, count=0, state=IDLE. After release, write 0x01 → clean frame.
6. Pointer wrap: stream 40 random bytes with FIFO_DEPTH=16 at random write gaps → decoded sequence matches the written sequence exactly, overflow=0.
